neopixel_frame_sequencer: RTL
=============================

NEOPIXEL_FRAME_SEQUENCER -- requirements
Module: neopixel_frame_sequencer

Interface
REQ-001 SHALL have parameter NUM_PIXELS, default 5, number of pixels on the strand (1..8).
REQ-002 SHALL have parameter FRAME_PERIOD, default 1_000_000, auto-refresh interval in clock cycles (>=2).
REQ-003 SHALL have port clock  in  1  single clock; all state updates on posedge clock.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port wr_en  in  1  host write strobe into the live colour buffer.
REQ-006 SHALL have ports wr_pixel  in  3, wr_color  in  2, and wr_level  in  8, giving target pixel, colour (00 red, 01 blue, 10 green, 11 invalid) and intensity.
REQ-007 SHALL have port frame_go  in  1  one-shot request to transmit one frame.
REQ-008 SHALL have port auto_en  in  1  enables periodic refresh every FRAME_PERIOD cycles.
REQ-009 SHALL have ports ready_to_load  in  1 and ready_to_send  in  1, status from the strand controller.
REQ-010 SHALL have ports load_color  out  1, pixel_index  out  3, color_index  out  2, color_level  out  8, and send_it  out  1, driving the strand controller.
REQ-011 SHALL have port busy  out  1  high whenever state != IDLE.
REQ-012 SHALL have ports frame_done  out  1 (one-cycle pulse at frame completion) and wr_err  out  1 (one-cycle pulse on a rejected write).

Function
REQ-013 SHALL hold a live buffer of NUM_PIXELS x 3 x 8 bits and a snapshot buffer of equal size.
REQ-014 SHALL, on wr_en with wr_color != 11 and wr_pixel < NUM_PIXELS, write wr_level to the live buffer at the next edge, in any state.
REQ-015 SHALL, on wr_en with wr_color == 11 or wr_pixel >= NUM_PIXELS, leave the buffer unchanged and assert wr_err for exactly the following cycle.
REQ-016 SHALL implement FSM states IDLE, LOAD, SEND, WAIT_BUSY, and WAIT_DONE.
REQ-017 SHALL treat start = frame_go | auto_tick | pending.
REQ-018 SHALL, in IDLE with start=1 and ready_to_load=1, copy live to snapshot, clear pending, set entry index to 0, and go to LOAD.
REQ-019 SHALL, in IDLE with start=1 and ready_to_load=0, set pending and stay in IDLE.
REQ-020 SHALL, when a write and a snapshot occur on the same edge, capture the pre-write value; the write affects the next frame.
REQ-021 SHALL, in LOAD, issue entries in order: pixel 0..NUM_PIXELS-1, and within each pixel green(10), red(00), blue(01), for a total of 3*NUM_PIXELS entries.
REQ-022 SHALL, in LOAD, drive load_color = ready_to_load combinationally, with pixel_index/color_index/color_level from the current entry of the snapshot.
REQ-023 SHALL advance the entry index only on cycles with load_color=1, and hold it while ready_to_load=0.
REQ-024 SHALL go to SEND on the edge that issues the last entry.
REQ-025 SHALL, in SEND, drive send_it = ready_to_send combinationally, and go to WAIT_BUSY on the edge where send_it=1.
REQ-026 SHALL, in WAIT_BUSY, go to WAIT_DONE when ready_to_load=0.
REQ-027 SHALL, in WAIT_DONE, go to IDLE when ready_to_load=1 and assert frame_done for exactly that transition's following cycle.
REQ-028 SHALL set pending on frame_go or auto_tick while state != IDLE; multiple requests coalesce into one pending frame.
REQ-029 SHALL run the auto counter only while auto_en=1; it counts 0..FRAME_PERIOD-1 and asserts auto_tick for one cycle at FRAME_PERIOD-1, then wraps to 0.
REQ-030 SHALL clear the auto counter to 0 whenever auto_en=0.
REQ-031 SHALL drive load_color=0 and send_it=0 outside LOAD and SEND, respectively; index outputs are don't-care when load_color=0 but SHALL be 0 in IDLE.

Reset
REQ-032 SHALL, on reset=1 at a posedge, force IDLE, clear pending, the entry index, the auto counter, both buffers, busy, frame_done and wr_err, and drive all strand outputs to 0.
REQ-033 SHALL abandon any in-progress frame on reset mid-frame, without emitting send_it and without pulsing frame_done.

Verification
REQ-034 SHALL verify a basic frame: write pixel4 red=FF and pixel0 blue=73, pulse frame_go with ready_to_load=1 -> 15 consecutive load_color pulses; entry 1 = (0,00,00), entry 2 = (0,01,73), entry 13 = (4,00,FF); then one send_it.
REQ-035 SHALL verify stalls: toggle ready_to_load low for 3 cycles mid-LOAD -> no entry skipped or duplicated, and exactly 15 loads in total.
REQ-036 SHALL verify rejected writes: wr_color=11 with pixel 1, level D4 -> wr_err one cycle, and the buffer is unchanged in the next frame.
REQ-037 SHALL verify coalescing and write timing: 3 frame_go pulses while busy -> exactly one extra frame after frame_done; a write on the snapshot edge appears only in the second frame.
REQ-038 SHALL verify auto refresh: auto_en=1 with FRAME_PERIOD=20 -> frames start at cycles 20 and 40 after enable; auto_en=0 -> no further starts.
REQ-039 SHALL verify reset mid-frame: reset during LOAD entry 7 -> next cycle busy=0 and no send_it/frame_done; a subsequent frame_go sends an all-zero frame.

Source files
------------

// File: rtl/neopixel_frame_sequencer.sv
// neopixel_frame_sequencer
// Holds a host-written colour buffer for a short NeoPixel strand and plays it
// out to a strand controller one colour entry at a time (G, R, B per pixel).
// Frames start on demand (frame_go) or periodically (auto_en). A request that
// cannot be served yet is remembered as a single pending frame.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | no frame in flight; waiting for a start and ready_to_load
// LOAD      | presenting snapshot entries, one per ready_to_load cycle
// SEND      | all entries loaded; waiting for ready_to_send to latch them
// WAIT_BUSY | send issued; waiting for the controller to drop ready_to_load
// WAIT_DONE | controller shifting data out; waiting for ready_to_load again
module neopixel_frame_sequencer #(
  parameter int NUM_PIXELS   = 5,
  parameter int FRAME_PERIOD = 1_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [2:0] wr_pixel,
  input  logic [1:0] wr_color,
  input  logic [7:0] wr_level,
  input  logic       frame_go,
  input  logic       auto_en,
  input  logic       ready_to_load,
  input  logic       ready_to_send,
  output logic       load_color,
  output logic [2:0] pixel_index,
  output logic [1:0] color_index,
  output logic [7:0] color_level,
  output logic       send_it,
  output logic       busy,
  output logic       frame_done,
  output logic       wr_err
);

  localparam int              CNT_W     = (FRAME_PERIOD > 2) ? $clog2(FRAME_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_PERIOD - 1);
  localparam logic [3:0]      PIX_COUNT = 4'(NUM_PIXELS);
  localparam logic [2:0]      PIX_LAST  = 3'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    SEND      = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  // Buffers are indexed [pixel][colour code]; code 00 red, 01 blue, 10 green.
  logic [7:0] live_buf [NUM_PIXELS][3];
  logic [7:0] snap_buf [NUM_PIXELS][3];

  // Entry index kept as pixel + position-within-pixel to avoid a divide by 3.
  logic [2:0]       pix_idx;
  logic [1:0]       sub_idx;
  logic             pending;
  logic [CNT_W-1:0] auto_cnt;

  logic       auto_tick;
  logic       start;
  logic       wr_ok;
  logic       snap_take;
  logic       last_entry;
  logic [1:0] entry_color;
  logic [7:0] entry_level;

  // Request and write qualification.
  always_comb begin
    wr_ok     = wr_en && (wr_color != 2'b11) && ({1'b0, wr_pixel} < PIX_COUNT);
    auto_tick = auto_en && (auto_cnt == CNT_LAST);
    start     = frame_go | auto_tick | pending;
    busy      = (state != IDLE);
  end

  // Current entry: colour order within a pixel is green, red, blue.
  always_comb begin
    entry_color = 2'b10;
    case (sub_idx)
      2'd0:    entry_color = 2'b10;
      2'd1:    entry_color = 2'b00;
      default: entry_color = 2'b01;
    endcase
    last_entry = (pix_idx == PIX_LAST) && (sub_idx == 2'd2);
  end

  // Snapshot read mux for the current entry.
  always_comb begin
    entry_level = '0;
    for (int p = 0; p < NUM_PIXELS; p++) begin
      for (int c = 0; c < 3; c++) begin
        if ((pix_idx == 3'(p)) && (entry_color == 2'(c))) begin
          entry_level = snap_buf[p][c];
        end
      end
    end
  end

  // FSM next state and strand-facing outputs.
  always_comb begin
    state_nxt   = state;
    load_color  = 1'b0;
    send_it     = 1'b0;
    pixel_index = '0;
    color_index = '0;
    color_level = '0;
    snap_take   = 1'b0;
    case (state)
      IDLE: begin
        if (start && ready_to_load) begin
          snap_take = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        load_color  = ready_to_load;
        pixel_index = pix_idx;
        color_index = entry_color;
        color_level = entry_level;
        if (ready_to_load && last_entry) begin
          state_nxt = SEND;
        end
      end
      SEND: begin
        send_it = ready_to_send;
        if (ready_to_send) begin
          state_nxt = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (!ready_to_load) begin
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (ready_to_load) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Nothing reaches the strand while reset is asserted, so a frame cut
    // short by reset can never emit a stray load or send.
    if (reset) begin
      load_color  = 1'b0;
      send_it     = 1'b0;
      pixel_index = '0;
      color_index = '0;
      color_level = '0;
      snap_take   = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Entry index: restarts on snapshot, advances only on accepted loads.
  always_ff @(posedge clock) begin
    if (reset || snap_take) begin
      pix_idx <= '0;
      sub_idx <= '0;
    end else if (load_color) begin
      if (sub_idx == 2'd2) begin
        sub_idx <= '0;
        pix_idx <= pix_idx + 3'd1;
      end else begin
        sub_idx <= sub_idx + 2'd1;
      end
    end
  end

  // Pending request: any number of requests collapse into one frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending <= 1'b0;
    end else if (state == IDLE) begin
      pending <= start && !ready_to_load;
    end else if (frame_go || auto_tick) begin
      pending <= 1'b1;
    end
  end

  // Auto-refresh counter, held at zero while disabled.
  always_ff @(posedge clock) begin
    if (reset || !auto_en) begin
      auto_cnt <= '0;
    end else if (auto_cnt == CNT_LAST) begin
      auto_cnt <= '0;
    end else begin
      auto_cnt <= auto_cnt + CNT_W'(1);
    end
  end

  // Single-cycle status pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_done <= 1'b0;
      wr_err     <= 1'b0;
    end else begin
      frame_done <= (state == WAIT_DONE) && ready_to_load;
      wr_err     <= wr_en && !wr_ok;
    end
  end

  // Live buffer: host writes land in any state.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int p = 0; p < NUM_PIXELS; p++) begin
        for (int c = 0; c < 3; c++) begin
          live_buf[p][c] <= '0;
        end
      end
    end else begin
      for (int p = 0; p < NUM_PIXELS; p++) begin
        for (int c = 0; c < 3; c++) begin
          if (wr_ok && (wr_pixel == 3'(p)) && (wr_color == 2'(c))) begin
            live_buf[p][c] <= wr_level;
          end
        end
      end
    end
  end

  // Snapshot buffer: nonblocking copy captures pre-write values on a shared edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int p = 0; p < NUM_PIXELS; p++) begin
        for (int c = 0; c < 3; c++) begin
          snap_buf[p][c] <= '0;
        end
      end
    end else if (snap_take) begin
      for (int p = 0; p < NUM_PIXELS; p++) begin
        for (int c = 0; c < 3; c++) begin
          snap_buf[p][c] <= live_buf[p][c];
        end
      end
    end
  end

endmodule
